// File: rtl/tpgen_pkg.sv
// Shared types and defaults for the time-pulse / phase sequencer.
//   tpgen_state_t : sequencer states
//   tpgen_load_t  : counter load selector driven by the FSM into the divider
//   DEF_*         : default parameter values
//   cnt_width()   : register width for a counter spanning 0..n-1 (min 1 bit)
package tpgen_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_GOJAM,
        ST_RUN,
        ST_STBY,
        ST_STOPPED,
        ST_STEP
    } tpgen_state_t;

    typedef enum logic [1:0] {
        LD_NONE,
        LD_CLEAR,
        LD_RUN,
        LD_STOP
    } tpgen_load_t;

    localparam int DEF_N_T         = 12;
    localparam int DEF_N_PH        = 4;
    localparam int DEF_DIV         = 2;
    localparam int DEF_GOJAM_TICKS = 4;
    localparam int DEF_FS_BITS     = 14;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tpgen_divider.sv
// Clock divider / phase / time-pulse counter chain.
//   SIM_CLK, SIM_RST : clock, synchronous active-high reset
//   load_sel         : LD_CLEAR all zero, LD_RUN T-last/phase 0, LD_STOP all last
//   freeze           : hold every counter
//   clr_pt           : keep ph/tp at zero while div_cnt keeps running
//   tick, bnd        : phase tick and MCT boundary for the current cycle
//   div_nxt/ph_nxt/tp_nxt : counter values for the next cycle
module tpgen_divider
    import tpgen_pkg::*;
#(
    parameter int N_T  = DEF_N_T,
    parameter int N_PH = DEF_N_PH,
    parameter int DIV  = DEF_DIV,
    localparam int TW  = cnt_width(N_T),
    localparam int PW  = cnt_width(N_PH),
    localparam int DW  = cnt_width(DIV)
) (
    input  logic          SIM_CLK,
    input  logic          SIM_RST,
    input  tpgen_load_t   load_sel,
    input  logic          freeze,
    input  logic          clr_pt,
    output logic          tick,
    output logic          bnd,
    output logic [DW-1:0] div_nxt,
    output logic [PW-1:0] ph_nxt,
    output logic [TW-1:0] tp_nxt
);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(N_PH - 1);
    localparam logic [TW-1:0] TP_LAST  = TW'(N_T - 1);

    logic [DW-1:0] div_cnt;
    logic [PW-1:0] ph;
    logic [TW-1:0] tp;

    assign tick = (div_cnt == DIV_LAST);
    assign bnd  = tick && (ph == PH_LAST) && (tp == TP_LAST);

    always_comb begin
        div_nxt = div_cnt;
        ph_nxt  = ph;
        tp_nxt  = tp;
        case (load_sel)
            LD_CLEAR: begin
                div_nxt = '0;
                ph_nxt  = '0;
                tp_nxt  = '0;
            end
            LD_RUN: begin
                div_nxt = '0;
                ph_nxt  = '0;
                tp_nxt  = TP_LAST;
            end
            LD_STOP: begin
                div_nxt = DIV_LAST;
                ph_nxt  = PH_LAST;
                tp_nxt  = TP_LAST;
            end
            default: begin
                if (!freeze) begin
                    div_nxt = tick ? '0 : div_cnt + 1'b1;
                    if (tick) begin
                        ph_nxt = (ph == PH_LAST) ? '0 : ph + 1'b1;
                        if (ph == PH_LAST)
                            tp_nxt = (tp == TP_LAST) ? '0 : tp + 1'b1;
                    end
                    if (clr_pt) begin
                        ph_nxt = '0;
                        tp_nxt = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            div_cnt <= '0;
            ph      <= '0;
            tp      <= '0;
        end else begin
            div_cnt <= div_nxt;
            ph      <= ph_nxt;
            tp      <= tp_nxt;
        end
    end

endmodule

// File: rtl/tpgen_param.sv
// Parametrised time-pulse and phase sequencer with restart, monitor
// stop/step, standby masking and optional MCT scaler.
//   SIM_CLK, SIM_RST      : clock, synchronous active-high reset
//   GOJ1, STRT            : restart requests (level)
//   SBY, MSTP             : standby / monitor stop requests (level)
//   MSTRTP                : single-MCT step pulse, honoured only when stopped
//   T, PHS                : one-hot time pulse / phase, zero when masked
//   GOJAM, STOP, STBY_ACT : state indications
//   MCT_END               : high on the last cycle of each MCT
//   FS, FS_TICK           : MCT scaler and its wrap pulse
// Build option: define TPGEN_SCALER_EN to build the scaler; otherwise
// FS and FS_TICK are constant zero.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_RESET   | held by SIM_RST, leaves to ST_GOJAM next cycle
// ST_GOJAM   | restart: counters cleared, gj_cnt counts down on ticks
// ST_RUN     | T/PHS driven, MCT boundary picks STBY/STOPPED/RUN
// ST_STBY    | counters run, outputs masked, leaves at boundary w/o SBY
// ST_STOPPED | counters frozen at MCT end, waits for MSTRTP or !MSTP
// ST_STEP    | one MCT as in RUN, then back to STOPPED or RUN
module tpgen_param
    import tpgen_pkg::*;
#(
    parameter int N_T         = DEF_N_T,
    parameter int N_PH        = DEF_N_PH,
    parameter int DIV         = DEF_DIV,
    parameter int GOJAM_TICKS = DEF_GOJAM_TICKS,
    parameter int FS_BITS     = DEF_FS_BITS
) (
    input  logic               SIM_CLK,
    input  logic               SIM_RST,
    input  logic               GOJ1,
    input  logic               STRT,
    input  logic               SBY,
    input  logic               MSTP,
    input  logic               MSTRTP,
    output logic [N_T-1:0]     T,
    output logic [N_PH-1:0]    PHS,
    output logic               GOJAM,
    output logic               STOP,
    output logic               STBY_ACT,
    output logic               MCT_END,
    output logic [FS_BITS-1:0] FS,
    output logic               FS_TICK
);

    localparam int TW = cnt_width(N_T);
    localparam int PW = cnt_width(N_PH);
    localparam int DW = cnt_width(DIV);
    localparam int GW = cnt_width(GOJAM_TICKS + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(N_PH - 1);
    localparam logic [TW-1:0] TP_LAST  = TW'(N_T - 1);
    localparam logic [GW-1:0] GJ_INIT  = GW'(GOJAM_TICKS);
    localparam logic [GW-1:0] GJ_ONE   = GW'(1);

    tpgen_state_t  state, state_nxt;
    logic [GW-1:0] gj_cnt, gj_nxt;
    tpgen_load_t   load_sel;
    logic          freeze, clr_pt, go_gj;
    logic          tick, bnd;
    logic [DW-1:0] div_nxt;
    logic [PW-1:0] ph_nxt;
    logic [TW-1:0] tp_nxt;

    logic [N_T-1:0]  t_nxt;
    logic [N_PH-1:0] phs_nxt;
    logic            gojam_nxt, stop_nxt, stby_nxt, mct_end_nxt;

    tpgen_divider #(
        .N_T  (N_T),
        .N_PH (N_PH),
        .DIV  (DIV)
    ) u_div (
        .SIM_CLK  (SIM_CLK),
        .SIM_RST  (SIM_RST),
        .load_sel (load_sel),
        .freeze   (freeze),
        .clr_pt   (clr_pt),
        .tick     (tick),
        .bnd      (bnd),
        .div_nxt  (div_nxt),
        .ph_nxt   (ph_nxt),
        .tp_nxt   (tp_nxt)
    );

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state  <= ST_RESET;
            gj_cnt <= '0;
        end else begin
            state  <= state_nxt;
            gj_cnt <= gj_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gj_nxt    = gj_cnt;
        load_sel  = LD_NONE;
        freeze    = 1'b0;
        clr_pt    = 1'b0;
        // Restart has priority over everything but SIM_RST, in every state.
        go_gj = GOJ1 | STRT | (state == ST_RESET)
              | ((state == ST_STBY) && bnd && !SBY);
        case (state)
            ST_GOJAM: begin
                clr_pt = 1'b1;
                if (tick) begin
                    if (gj_cnt == GJ_ONE) begin
                        state_nxt = ST_RUN;
                        load_sel  = LD_RUN;
                        gj_nxt    = '0;
                    end else begin
                        gj_nxt = gj_cnt - 1'b1;
                    end
                end
            end
            ST_RUN, ST_STEP: begin
                if (bnd) begin
                    if (SBY) begin
                        state_nxt = ST_STBY;
                    end else if (MSTP) begin
                        state_nxt = ST_STOPPED;
                        load_sel  = LD_STOP;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_STOPPED: begin
                // Leaving STOPPED lets the frozen counters wrap into T1/phase 0.
                if (MSTRTP)
                    state_nxt = ST_STEP;
                else if (!MSTP)
                    state_nxt = ST_RUN;
                else
                    freeze = 1'b1;
            end
            default: ;
        endcase
        if (go_gj) begin
            state_nxt = ST_GOJAM;
            load_sel  = LD_CLEAR;
            freeze    = 1'b0;
            clr_pt    = 1'b0;
            gj_nxt    = GJ_INIT;
        end
    end

    // Outputs are decoded from next-cycle state/counters and registered, so
    // MCT_END lands on the last cycle of the MCT rather than one late.
    always_comb begin
        t_nxt   = '0;
        phs_nxt = '0;
        if (state_nxt == ST_RUN || state_nxt == ST_STEP) begin
            t_nxt[tp_nxt]   = 1'b1;
            phs_nxt[ph_nxt] = 1'b1;
        end
        gojam_nxt   = (state_nxt == ST_RESET) || (state_nxt == ST_GOJAM);
        stop_nxt    = (state_nxt == ST_STOPPED);
        stby_nxt    = (state_nxt == ST_STBY);
        mct_end_nxt = (state_nxt == ST_RUN || state_nxt == ST_STEP
                       || state_nxt == ST_STBY)
                      && (div_nxt == DIV_LAST) && (ph_nxt == PH_LAST)
                      && (tp_nxt == TP_LAST);
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            T        <= '0;
            PHS      <= '0;
            GOJAM    <= 1'b1;
            STOP     <= 1'b0;
            STBY_ACT <= 1'b0;
            MCT_END  <= 1'b0;
        end else begin
            T        <= t_nxt;
            PHS      <= phs_nxt;
            GOJAM    <= gojam_nxt;
            STOP     <= stop_nxt;
            STBY_ACT <= stby_nxt;
            MCT_END  <= mct_end_nxt;
        end
    end

`ifdef TPGEN_SCALER_EN
    logic fs_inc;

    assign fs_inc = bnd && (state == ST_RUN || state == ST_STEP
                            || state == ST_STBY);

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            FS      <= '0;
            FS_TICK <= 1'b0;
        end else begin
            FS_TICK <= fs_inc && (FS == '1);
            if (fs_inc)
                FS <= FS + 1'b1;
        end
    end
`else
    assign FS      = '0;
    assign FS_TICK = 1'b0;
`endif

endmodule

// File: tb/tb_tpgen_param.sv
// Bench for tpgen_param: randomized scenario stimulus, a position-in-MCT
// reference model, and a queue-based scoreboard checked on the falling edge.
module tb_tpgen_param;

    localparam int N_T    = 12;
    localparam int N_PH   = 4;
    localparam int DIV    = 2;
    localparam int GJT    = 4;
    localparam int FSB    = 2;
    localparam int MCT    = N_T * N_PH * DIV;
    localparam int TP_CYC = N_PH * DIV;
    localparam int GJ_CYC = GJT * DIV;

    logic SIM_CLK = 1'b0;
    logic SIM_RST, GOJ1, STRT, SBY, MSTP, MSTRTP;
    logic [N_T-1:0]  T;
    logic [N_PH-1:0] PHS;
    logic            GOJAM, STOP, STBY_ACT, MCT_END, FS_TICK;
    logic [FSB-1:0]  FS;

    tpgen_param #(
        .N_T         (N_T),
        .N_PH        (N_PH),
        .DIV         (DIV),
        .GOJAM_TICKS (GJT),
        .FS_BITS     (FSB)
    ) dut (
        .SIM_CLK  (SIM_CLK),
        .SIM_RST  (SIM_RST),
        .GOJ1     (GOJ1),
        .STRT     (STRT),
        .SBY      (SBY),
        .MSTP     (MSTP),
        .MSTRTP   (MSTRTP),
        .T        (T),
        .PHS      (PHS),
        .GOJAM    (GOJAM),
        .STOP     (STOP),
        .STBY_ACT (STBY_ACT),
        .MCT_END  (MCT_END),
        .FS       (FS),
        .FS_TICK  (FS_TICK)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    typedef struct packed {
        logic [N_T-1:0]  t;
        logic [N_PH-1:0] phs;
        logic            gojam;
        logic            stop;
        logic            stby;
        logic            mct_end;
        logic [FSB-1:0]  fs;
        logic            fs_tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode plus cycle position inside the MCT (0..MCT-1).
    typedef enum int {M_RST, M_GJ, M_RUN, M_SBY, M_STOP, M_STEP} mode_t;
    mode_t mode     = M_RST;
    int    pos      = 0;
    int    gj_left  = 0;
    int    fs_model = 0;
    bit    fs_wrap  = 1'b0;

    function automatic bit counting();
        return mode == M_RUN || mode == M_STEP || mode == M_SBY;
    endfunction

    task automatic model_step(input logic rst, goj, strt, sby, mstp, mstrtp);
        bit last;
        last    = counting() && (pos == MCT - 1);
        fs_wrap = 1'b0;
        if (rst) begin
            mode     = M_RST;
            pos      = 0;
            fs_model = 0;
            return;
        end
        if (last) begin
            fs_model = (fs_model + 1) % (1 << FSB);
            fs_wrap  = (fs_model == 0);
        end
        if (mode == M_RST || goj || strt) begin
            mode    = M_GJ;
            gj_left = GJ_CYC;
            return;
        end
        case (mode)
            M_GJ: begin
                gj_left--;
                if (gj_left == 0) begin
                    mode = M_RUN;
                    pos  = MCT - TP_CYC;
                end
            end
            M_RUN, M_STEP: begin
                if (!last) pos++;
                else if (sby) begin mode = M_SBY; pos = 0; end
                else if (mstp) mode = M_STOP;
                else begin mode = M_RUN; pos = 0; end
            end
            M_SBY: begin
                if (!last) pos++;
                else if (!sby) begin mode = M_GJ; gj_left = GJ_CYC; end
                else pos = 0;
            end
            M_STOP: begin
                if (mstrtp) begin mode = M_STEP; pos = 0; end
                else if (!mstp) begin mode = M_RUN; pos = 0; end
            end
            default: ;
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        if (mode == M_RUN || mode == M_STEP) begin
            e.t[pos / TP_CYC]        = 1'b1;
            e.phs[(pos / DIV) % N_PH] = 1'b1;
        end
        e.gojam   = (mode == M_RST) || (mode == M_GJ);
        e.stop    = (mode == M_STOP);
        e.stby    = (mode == M_SBY);
        e.mct_end = counting() && (pos == MCT - 1);
`ifdef TPGEN_SCALER_EN
        e.fs      = FSB'(fs_model);
        e.fs_tick = fs_wrap;
`endif
        return e;
    endfunction

    // One clock: the DUT and the model both see the inputs currently driven.
    task automatic cyc();
        @(posedge SIM_CLK);
        model_step(SIM_RST, GOJ1, STRT, SBY, MSTP, MSTRTP);
        exp_q.push_back(model_out());
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                         name, $time, act, req);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge SIM_CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("T",        32'(T),        32'(e.t));
                chk("PHS",      32'(PHS),      32'(e.phs));
                chk("GOJAM",    32'(GOJAM),    32'(e.gojam));
                chk("STOP",     32'(STOP),     32'(e.stop));
                chk("STBY_ACT", 32'(STBY_ACT), 32'(e.stby));
                chk("MCT_END",  32'(MCT_END),  32'(e.mct_end));
                chk("FS",       32'(FS),       32'(e.fs));
                chk("FS_TICK",  32'(FS_TICK),  32'(e.fs_tick));
            end
        end
    end

    initial begin
        SIM_RST = 1'b1;
        GOJ1    = 1'b0;
        STRT    = 1'b0;
        SBY     = 1'b0;
        MSTP    = 1'b0;
        MSTRTP  = 1'b0;
        repeat (3) cyc();
        SIM_RST = 1'b0;
        repeat (400) cyc();

        // Restart request part-way through an MCT.
        repeat ($urandom_range(0, MCT - 1)) cyc();
        GOJ1 = 1'b1; cyc(); GOJ1 = 1'b0;
        repeat (200) cyc();

        // Alarm restart held for a while.
        STRT = 1'b1;
        repeat ($urandom_range(1, 20)) cyc();
        STRT = 1'b0;
        repeat (150) cyc();

        // Monitor stop and two single steps.
        MSTP = 1'b1;
        repeat (250) cyc();
        MSTRTP = 1'b1; cyc(); MSTRTP = 1'b0;
        repeat (150) cyc();
        MSTRTP = 1'b1; cyc(); MSTRTP = 1'b0;
        repeat (120) cyc();
        MSTP = 1'b0;
        repeat (200) cyc();

        // Standby in and out.
        SBY = 1'b1;
        repeat (400) cyc();
        SBY = 1'b0;
        repeat (300) cyc();

        // Standby and stop requested together.
        SBY  = 1'b1;
        MSTP = 1'b1;
        repeat (300) cyc();
        SBY = 1'b0;
        repeat (250) cyc();
        MSTP = 1'b0;
        repeat (200) cyc();

        // Random mix of all controls.
        repeat (3000) begin
            GOJ1   = ($urandom_range(0, 199) == 0);
            STRT   = ($urandom_range(0, 399) == 0);
            MSTRTP = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) SBY  = ~SBY;
            if ($urandom_range(0, 249) == 0) MSTP = ~MSTP;
            cyc();
        end
        GOJ1   = 1'b0;
        STRT   = 1'b0;
        SBY    = 1'b0;
        MSTP   = 1'b0;
        MSTRTP = 1'b0;
        repeat (150) cyc();

        // Reset in the middle of operation.
        SIM_RST = 1'b1; cyc(); SIM_RST = 1'b0;
        repeat (200) cyc();

        @(negedge SIM_CLK);
        @(negedge SIM_CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tpgen_param.md
# tpgen_param

Parametrised time-pulse and phase sequencer for the AGC simulation: divides `SIM_CLK` into phases, phases into one-hot time pulses T1..T`N_T`, and T pulses into memory cycles (MCT). Adds a restart (GOJAM) sequencer, monitor stop/single-MCT step, standby masking and an optional MCT scaler. It sits where the gate-level timer does today and feeds the control-pulse generators and monitor outputs.

## Interface
Parameters:
- `N_T`, 12, time pulses per MCT (≥2).
- `N_PH`, 4, phases per time pulse (≥2).
- `DIV`, 2, `SIM_CLK` cycles per phase (≥1).
- `GOJAM_TICKS`, 4, phase ticks GOJAM stays high after its cause clears (≥1).
- `FS_BITS`, 14, scaler width.

Ports:
- `SIM_CLK` in 1: the only clock.
- `SIM_RST` in 1: synchronous, active-high reset.
- `GOJ1` in 1: external restart request, level.
- `STRT` in 1: alarm restart request, level.
- `SBY` in 1: standby request, level.
- `MSTP` in 1: monitor stop, level.
- `MSTRTP` in 1: monitor start; a one-cycle pulse runs one MCT.
- `T` out `N_T`: one-hot time pulse; all zero when masked.
- `PHS` out `N_PH`: one-hot phase; all zero when masked.
- `GOJAM` out 1: restart in progress.
- `STOP` out 1: stopped by monitor.
- `STBY_ACT` out 1: in standby.
- `MCT_END` out 1: one-cycle pulse on the last cycle of each MCT.
- `FS` out `FS_BITS`: MCT scaler count.
- `FS_TICK` out 1: one-cycle pulse when `FS` wraps to 0.

## Operation
- Internal counters: `div_cnt` (0..`DIV`-1), `ph` (0..`N_PH`-1), `tp` (0..`N_T`-1).
- A tick occurs when `div_cnt`=`DIV`-1. On a tick, `ph` advances; `tp` advances when `ph` wraps.
- The MCT boundary is a tick with `ph`=`N_PH`-1 and `tp`=`N_T`-1.
- States:
  - RESET: entered by `SIM_RST`; exits to GOJAM on the next cycle.
  - GOJAM: counters cleared and `gj_cnt` loaded with `GOJAM_TICKS`.
    - While `GOJ1`|`STRT` is high, `gj_cnt` is reloaded.
    - Otherwise `gj_cnt` decrements each tick.
    - At 0, exit to RUN with `tp`=`N_T`-1 and `ph`=0 (first pulse seen is T`N_T`).
  - RUN: `T[tp]` and `PHS[ph]` are driven. At the MCT boundary:
    - `SBY` → STBY.
    - else `MSTP` → STOPPED.
    - else stay in RUN.
  - STBY: counters and scaler keep running; `T`/`PHS` are masked. At an MCT boundary with `SBY` low → GOJAM.
  - STOPPED: counters and scaler are frozen at `tp`=`N_T`-1, `ph`=`N_PH`-1, `div_cnt`=`DIV`-1; `T`/`PHS` are masked.
    - `MSTRTP` → STEP.
    - `MSTP` low → RUN; the next cycle is the T1/phase 0 tick.
  - STEP: runs exactly one MCT as in RUN. At its boundary, go to STOPPED if `MSTP` is high, else RUN.
- Priority, highest first: `SIM_RST` > `GOJ1`|`STRT` (any state except RESET → GOJAM the next cycle) > `SBY` > `MSTP`.
- Scaler: `FS` increments at each MCT boundary in RUN, STEP and STBY, wrapping modulo 2^`FS_BITS`. `FS_TICK` pulses in the same cycle `FS` becomes 0.
- `GOJAM` is high in RESET and GOJAM. `STOP` is high in STOPPED. `STBY_ACT` is high in STBY.

## Timing
- All outputs are registered and change one cycle after the causing edge.
- Reset values:
  - `T`=0, `PHS`=0, `MCT_END`=0, `STOP`=0, `STBY_ACT`=0, `FS`=0, `FS_TICK`=0.
  - `GOJAM`=1.
- MCT length is `N_T`·`N_PH`·`DIV` cycles (96 with defaults).
- Each `PHS` bit is high for `DIV` cycles. Each `T` bit is high for `N_PH`·`DIV` cycles.
- GOJAM duration after the cause clears is `GOJAM_TICKS`·`DIV` cycles. `GOJAM` falls in the same cycle `T[N_T-1]` rises.
- A restart request is honoured mid-MCT; the partial MCT is abandoned and produces no `MCT_END`.
- `MSTRTP` is ignored outside STOPPED.
- `SIM_RST` mid-operation returns every output to its reset value on the next edge.

## Configuration
- `TPGEN_SCALER_EN` defined: scaler present as described.
- Not defined: `FS` is tied to 0, `FS_TICK` is tied to 0 and no scaler flops are built. All other behaviour is unchanged.

## Structure
- A shared package `tpgen_pkg` holds:
  - the state enum `tpgen_state_t` (RESET, GOJAM, RUN, STBY, STOPPED, STEP);
  - default parameter constants.
- One sub-module, `tpgen_divider`, contains `div_cnt`/`ph`/`tp` with load, freeze and tick/boundary outputs.
- The state machine, masking and scaler live in the top module.

## Test plan
- Reset, then all inputs low (defaults):
  - `GOJAM`=1 for 1+8 cycles;
  - then `T[11]` is high for 8 cycles;
  - then `T[0]`…;
  - `MCT_END` pulses every 96 cycles.
- `GOJ1` pulsed at `tp`=5 in RUN: next cycle `GOJAM`=1 and `T`=0; 8 cycles later `T[11]` rises; no `MCT_END` for the aborted MCT.
- `MSTP`=1:
  - `STOP` rises after the next `MCT_END`, `T`=0 and `FS` is frozen.
  - An `MSTRTP` pulse gives exactly 96 cycles of pulses T1..T12, one `MCT_END` and `FS`+1, then `STOP`=1 again.
- `SBY`=1 in RUN:
  - `STBY_ACT` rises at the boundary and `T`/`PHS` go to 0 while `FS` keeps incrementing every 96 cycles.
  - Dropping `SBY` gives `GOJAM` at the next boundary.
- `SBY`=1 and `MSTP`=1 at the same boundary → STBY (not STOPPED).
- `FS_BITS`=2 with the macro defined: `FS_TICK` pulses at every 4th `MCT_END`. Without the macro, `FS`=0 throughout.
